// File: rtl/mux_n_1_stream_if.sv
// mux_n_1_stream_if: per-channel input streams and the single registered output stream
interface mux_n_1_stream_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_ch;
    logic                    seq_done;
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch, seq_done
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch, seq_done
    );
endinterface

// File: rtl/mux_n_1_stream.sv
// mux_n_1_stream: registered N:1 stream selector, fixed-select or auto-sequence over all channels
module mux_n_1_stream #(
    parameter int  WIDTH  = 16,
    parameter int  NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             mode_i,
    input  logic             start_i,
    input  logic [SEL_W-1:0] sel_i,
    mux_n_1_stream_if.slave  s
);
    typedef enum logic {IDLE, RUN} state_e;
    state_e            state_q, state_d;
    logic [SEL_W-1:0]  run_ch_q, run_ch_d, out_ch_q, out_ch_d, cur_ch;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d, seq_done_q, seq_done_d;
    logic              fixed, active, load_ok, xfer, last;
    logic [NUM_IN-1:0] ready;
    always_comb begin
        fixed    = state_q == IDLE && !mode_i;
        cur_ch   = fixed ? sel_i : (state_q == RUN ? run_ch_q : '0);
        load_ok  = !out_valid_q || s.out_ready;
        // an out-of-range select in fixed mode leaves every channel unselected
        active   = rst_n && !clear_i && (fixed || state_q == RUN) && int'(cur_ch) < NUM_IN && load_ok;
        ready    = active ? NUM_IN'(1) << cur_ch : '0;
        xfer     = |(ready & s.in_valid);
        last     = cur_ch == SEL_W'(NUM_IN - 1);
        state_d     = state_q;
        run_ch_d    = run_ch_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        seq_done_d  = 1'b0;
        if (clear_i) begin
            state_d     = IDLE;
            run_ch_d    = '0;
            out_data_d  = '0;
            out_ch_d    = '0;
            out_valid_d = 1'b0;
        end else begin
            if (xfer) begin
                out_data_d  = s.in_data[cur_ch*WIDTH +: WIDTH];
                out_ch_d    = cur_ch;
                out_valid_d = 1'b1;
            end else if (out_valid_q && s.out_ready) begin
                out_valid_d = 1'b0;
            end
            if (state_q == IDLE && mode_i && start_i) begin
                state_d  = RUN;
                run_ch_d = '0;
            end else if (state_q == RUN && xfer) begin
                state_d    = last ? IDLE : RUN;
                run_ch_d   = last ? '0 : run_ch_q + SEL_W'(1);
                seq_done_d = last;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            run_ch_q    <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_ch_q    <= run_ch_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            seq_done_q  <= seq_done_d;
        end
    end
    assign s.in_ready  = ready;
    assign s.out_data  = out_data_q;
    assign s.out_ch    = out_ch_q;
    assign s.out_valid = out_valid_q;
    assign s.seq_done  = seq_done_q;
endmodule

// File: tb/tb_mux_n_1_stream.sv
// tb_mux_n_1_stream: directed vectors for the 4-channel build plus a 3-channel out-of-range select check
module tb_mux_n_1_stream;
    logic       clk = 1'b0;
    logic       rst_n, clear_i, mode_i, start_i;
    logic [1:0] sel_i, sel3_i;
    int         vectors = 0;
    int         miscompares = 0;
    mux_n_1_stream_if #(.WIDTH(16), .NUM_IN(4)) ifc ();
    mux_n_1_stream_if #(.WIDTH(16), .NUM_IN(3)) ifc3 ();
    mux_n_1_stream #(.WIDTH(16), .NUM_IN(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .mode_i(mode_i),
        .start_i(start_i), .sel_i(sel_i), .s(ifc)
    );
    mux_n_1_stream #(.WIDTH(16), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .clear_i(1'b0), .mode_i(1'b0),
        .start_i(1'b0), .sel_i(sel3_i), .s(ifc3)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic [1:0] ch, input logic sd);
        chk({tag, ".valid"}, 32'(ifc.out_valid), 32'(v));
        chk({tag, ".data"}, 32'(ifc.out_data), 32'(d));
        chk({tag, ".ch"}, 32'(ifc.out_ch), 32'(ch));
        chk({tag, ".done"}, 32'(ifc.seq_done), 32'(sd));
    endtask
    initial begin
        rst_n = 1'b0; clear_i = 1'b0; mode_i = 1'b0; start_i = 1'b0;
        sel_i = 2'd1; sel3_i = 2'd3;
        ifc.in_data   = {16'h0000, 16'h0100, 16'h0200, 16'h0300};
        ifc.in_valid  = 4'hF;
        ifc.out_ready = 1'b1;
        ifc3.in_data   = {16'h00AA, 16'h00BB, 16'h00CC};
        ifc3.in_valid  = 3'b111;
        ifc3.out_ready = 1'b1;
        #2;
        chk_out("reset", 1'b0, 16'h0, 2'd0, 1'b0);
        chk("reset.ready", 32'(ifc.in_ready), 32'h0);
        #10 rst_n = 1'b1;
        #1;
        // fixed select
        chk("t1.ready_sel1", 32'(ifc.in_ready), 32'b0010);
        tick();
        chk_out("t1.sel1", 1'b1, 16'h0200, 2'd1, 1'b0);
        sel_i = 2'd0;
        #1 chk("t1.ready_sel0", 32'(ifc.in_ready), 32'b0001);
        tick();
        chk_out("t1.sel0", 1'b1, 16'h0300, 2'd0, 1'b0);
        // backpressure
        sel_i = 2'd2;
        tick();
        chk_out("t2.load2", 1'b1, 16'h0100, 2'd2, 1'b0);
        ifc.out_ready = 1'b0;
        tick();
        chk_out("t2.hold", 1'b1, 16'h0100, 2'd2, 1'b0);
        sel_i = 2'd3;
        #1 chk("t2.ready_full", 32'(ifc.in_ready), 32'h0);
        tick();
        chk_out("t2.hold_sel3", 1'b1, 16'h0100, 2'd2, 1'b0);
        ifc.out_ready = 1'b1;
        #1 chk("t2.ready_drain", 32'(ifc.in_ready), 32'b1000);
        tick();
        chk_out("t2.load3", 1'b1, 16'h0000, 2'd3, 1'b0);
        ifc.in_valid = 4'h0;
        tick();
        chk_out("t2.drained", 1'b0, 16'h0000, 2'd3, 1'b0);
        // auto sequence
        ifc.in_valid = 4'hF;
        mode_i = 1'b1; start_i = 1'b1;
        #1 chk("t3.ready_idle", 32'(ifc.in_ready), 32'h0);
        tick();
        start_i = 1'b0;
        #1 chk("t3.ready_ch0", 32'(ifc.in_ready), 32'b0001);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out($sformatf("t3.ch%0d", k), 1'b1, 16'(16'h0300 - k * 16'h0100), 2'(k), k == 3);
        end
        chk("t3.ready_after", 32'(ifc.in_ready), 32'h0);
        tick();
        chk_out("t3.idle", 1'b0, 16'h0000, 2'd3, 1'b0);
        // stall on channel 2
        ifc.in_valid = 4'b1011;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        chk_out("t4.ch0", 1'b1, 16'h0300, 2'd0, 1'b0);
        tick();
        chk_out("t4.ch1", 1'b1, 16'h0200, 2'd1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4.stall_ready%0d", k), 32'(ifc.in_ready), 32'b0100);
            tick();
            chk($sformatf("t4.stall_valid%0d", k), 32'(ifc.out_valid), 32'h0);
        end
        ifc.in_valid = 4'hF;
        tick();
        chk_out("t4.ch2", 1'b1, 16'h0100, 2'd2, 1'b0);
        tick();
        chk_out("t4.ch3", 1'b1, 16'h0000, 2'd3, 1'b1);
        tick();
        // clear mid-sequence, asserted together with start
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        chk_out("t5.ch1", 1'b1, 16'h0200, 2'd1, 1'b0);
        clear_i = 1'b1; start_i = 1'b1;
        #1 chk("t5.ready_clear", 32'(ifc.in_ready), 32'h0);
        tick();
        chk_out("t5.cleared", 1'b0, 16'h0000, 2'd0, 1'b0);
        clear_i = 1'b0; start_i = 1'b0;
        #1 chk("t5.ready_idle", 32'(ifc.in_ready), 32'h0);
        tick();
        chk_out("t5.no_done", 1'b0, 16'h0000, 2'd0, 1'b0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        chk_out("t5.restart", 1'b1, 16'h0300, 2'd0, 1'b0);
        tick();
        chk_out("t6.ch1", 1'b1, 16'h0200, 2'd1, 1'b0);
        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk_out("t6.async", 1'b0, 16'h0000, 2'd0, 1'b0);
        chk("t6.ready", 32'(ifc.in_ready), 32'h0);
        chk("t6.n3_valid", 32'(ifc3.out_valid), 32'h0);
        #4 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("t6.after%0d", k), 1'b0, 16'h0000, 2'd0, 1'b0);
        end
        // 3-channel build: sel=3 selects nothing
        chk("t6.n3_ready_sel3", 32'(ifc3.in_ready), 32'b000);
        chk("t6.n3_idle", 32'(ifc3.out_valid), 32'h0);
        sel3_i = 2'd2;
        #1 chk("t6.n3_ready_sel2", 32'(ifc3.in_ready), 32'b100);
        tick();
        chk("t6.n3_data", 32'(ifc3.out_data), 32'h00AA);
        chk("t6.n3_ch", 32'(ifc3.out_ch), 32'd2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
